// File: rtl/pl_int_ctrl.sv
// Priority interrupt controller feeding the pipelined CPU's single intr/inta handshake.
// Pending latches, mask, edge/level mode, in-service tracking and a vector register.
module pl_int_ctrl #(
  parameter int N     = 8,
  parameter int VBITS = 4
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [N-1:0]  irq_src,
  input  logic          inta,
  output logic          intr,
  input  logic [2:0]    addr,
  input  logic [31:0]   wdata,
  input  logic          we,
  output logic [31:0]   rdata
);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_REQ  = 1'b1;

  logic             state;
  logic [N-1:0]     src_q;
  logic [N-1:0]     pend;
  logic [N-1:0]     mask;
  logic [N-1:0]     edge_mode;
  logic [N-1:0]     isr;
  logic             vec_valid;
  logic [VBITS-1:0] vec_idx;

  logic [VBITS-1:0] cand;
  logic [N-1:0]     cand_oh;
  logic             found;
  logic             blocked;
  logic             eligible;
  logic             accept;
  logic             eoi_wr;
  logic [N-1:0]     pend_w1c;
  logic [N-1:0]     ack_clr;
  logic [N-1:0]     edge_next;
  logic [N-1:0]     pend_next;
  logic [N-1:0]     isr_next;
  logic             unused_wdata;

  // Lowest enabled pending source wins; it may only interrupt if nothing of equal
  // or higher priority is already in service.
  always_comb begin
    cand     = '0;
    cand_oh  = '0;
    found    = 1'b0;
    blocked  = 1'b0;
    eligible = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && pend[i] && mask[i]) begin
        found      = 1'b1;
        cand       = VBITS'(i);
        cand_oh[i] = 1'b1;
        eligible   = !(blocked || isr[i]);
      end
      blocked = blocked | isr[i];
    end
  end

  assign accept   = (state == STATE_REQ) && inta && eligible;
  assign eoi_wr   = we && (addr == 3'd5);
  assign pend_w1c = (we && addr == 3'd0) ? wdata[N-1:0] : '0;
  assign ack_clr  = accept ? cand_oh : '0;

  // A new rising edge beats both a software clear and the acknowledge clear.
  assign edge_next = (pend & ~pend_w1c & ~ack_clr) | (irq_src & ~src_q);
  assign pend_next = (edge_mode & edge_next) | (~edge_mode & irq_src);
  assign isr_next  = (eoi_wr ? (isr & (isr - N'(1))) : isr) | ack_clr;

  assign unused_wdata = ^wdata[31:N];

  always_ff @(posedge clk) begin
    if (clrn) begin
      src_q     <= '0;
      pend      <= '0;
      mask      <= '0;
      edge_mode <= '0;
      isr       <= '0;
      vec_valid <= 1'b0;
      vec_idx   <= '0;
    end else begin
      src_q <= irq_src;
      pend  <= pend_next;
      isr   <= isr_next;
      if (we && addr == 3'd1) mask      <= wdata[N-1:0];
      if (we && addr == 3'd2) edge_mode <= wdata[N-1:0];
      if (inta) begin
        vec_valid <= accept;
        vec_idx   <= accept ? cand : VBITS'(N);
      end
    end
  end

  // Any inta closes the request; a withdrawn candidate also drops it.
  always_ff @(posedge clk) begin
    if (clrn) begin
      state <= STATE_IDLE;
    end else begin
      case (state)
        STATE_IDLE: if (eligible) state <= STATE_REQ;
        STATE_REQ:  if (inta || !eligible) state <= STATE_IDLE;
        default:    state <= STATE_IDLE;
      endcase
    end
  end

  assign intr = (state == STATE_REQ);

  always_comb begin
    rdata = '0;
    case (addr)
      3'd0: rdata = 32'(pend);
      3'd1: rdata = 32'(mask);
      3'd2: rdata = 32'(edge_mode);
      3'd3: rdata = 32'(isr);
      3'd4: begin
        rdata[VBITS-1:0] = vec_idx;
        rdata[31]        = vec_valid;
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pl_int_ctrl.sv
// Directed self-checking bench for pl_int_ctrl: edge/level sources, priority,
// nesting, spurious acknowledge and synchronous reset.
module tb_pl_int_ctrl;

  logic        clk = 1'b0;
  logic        clrn;
  logic [7:0]  irq_src;
  logic        inta;
  logic        intr;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  int checks   = 0;
  int failures = 0;

  pl_int_ctrl #(.N(8), .VBITS(4)) dut (
    .clk     (clk),
    .clrn    (clrn),
    .irq_src (irq_src),
    .inta    (inta),
    .intr    (intr),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .rdata   (rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic checkReg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    checkOutput(tag, rdata, exp);
  endtask

  // Drive request lines and acknowledge for one clock, then release acknowledge.
  task automatic applyStimulus(input logic [7:0] src, input logic ack);
    irq_src = src;
    inta    = ack;
    step();
    inta    = 1'b0;
  endtask

  initial begin
    clrn = 1'b1; irq_src = '0; inta = 1'b0; addr = '0; wdata = '0; we = 1'b0;
    step();
    step();
    clrn = 1'b0;
    checkOutput("reset_intr", {31'b0, intr}, 32'h0);
    checkReg("reset_pend", 3'd0, 32'h0);
    checkReg("reset_vec", 3'd4, 32'h0);

    // Single edge source
    writeReg(3'd1, 32'h01);
    writeReg(3'd2, 32'h01);
    applyStimulus(8'h01, 1'b0);
    checkOutput("edge_intr_k", {31'b0, intr}, 32'h0);
    checkReg("edge_pend_k", 3'd0, 32'h01);
    applyStimulus(8'h00, 1'b0);
    checkOutput("edge_intr_k1", {31'b0, intr}, 32'h1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("edge_intr_ack", {31'b0, intr}, 32'h0);
    checkReg("edge_vec", 3'd4, 32'h8000_0000);
    checkReg("edge_isr", 3'd3, 32'h01);
    checkReg("edge_pend_ack", 3'd0, 32'h00);
    writeReg(3'd5, 32'h0);
    checkReg("edge_isr_eoi", 3'd3, 32'h00);

    // Priority between sources 5 and 2
    writeReg(3'd2, 32'hFF);
    writeReg(3'd1, 32'hFF);
    applyStimulus(8'h24, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("prio_intr", {31'b0, intr}, 32'h1);
    checkReg("prio_pend", 3'd0, 32'h24);
    applyStimulus(8'h00, 1'b1);
    checkReg("prio_vec2", 3'd4, 32'h8000_0002);
    checkReg("prio_isr2", 3'd3, 32'h04);
    checkReg("prio_pend5", 3'd0, 32'h20);
    step();
    checkOutput("prio_blocked", {31'b0, intr}, 32'h0);
    writeReg(3'd5, 32'h0);
    step();
    checkOutput("prio_reassert", {31'b0, intr}, 32'h1);
    applyStimulus(8'h00, 1'b1);
    checkReg("prio_vec5", 3'd4, 32'h8000_0005);
    writeReg(3'd5, 32'h0);
    checkReg("prio_isr_clr", 3'd3, 32'h00);

    // Nesting under source 3 in service
    applyStimulus(8'h08, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b1);
    checkReg("nest_isr3", 3'd3, 32'h08);
    applyStimulus(8'h40, 1'b0);
    applyStimulus(8'h00, 1'b0);
    step();
    checkOutput("nest_low_blocked", {31'b0, intr}, 32'h0);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("nest_high_intr", {31'b0, intr}, 32'h1);
    applyStimulus(8'h00, 1'b1);
    checkReg("nest_vec1", 3'd4, 32'h8000_0001);
    checkReg("nest_isr_0a", 3'd3, 32'h0A);
    writeReg(3'd5, 32'h0);
    checkReg("nest_isr_eoi", 3'd3, 32'h08);
    writeReg(3'd5, 32'h0);
    step();
    checkOutput("nest_src6_intr", {31'b0, intr}, 32'h1);
    applyStimulus(8'h00, 1'b1);
    checkReg("nest_vec6", 3'd4, 32'h8000_0006);
    writeReg(3'd5, 32'h0);

    // Level mode on source 4
    writeReg(3'd2, 32'h00);
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h10, 1'b0);
    checkOutput("lvl_intr", {31'b0, intr}, 32'h1);
    applyStimulus(8'h10, 1'b1);
    checkReg("lvl_vec4", 3'd4, 32'h8000_0004);
    checkReg("lvl_pend_ack", 3'd0, 32'h10);
    writeReg(3'd0, 32'h10);
    checkReg("lvl_pend_w1c", 3'd0, 32'h10);
    applyStimulus(8'h00, 1'b0);
    checkReg("lvl_pend_drop", 3'd0, 32'h00);
    writeReg(3'd5, 32'h0);
    checkReg("lvl_isr_clr", 3'd3, 32'h00);

    // Withdrawn request followed by a spurious acknowledge
    writeReg(3'd2, 32'hFF);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("spur_intr", {31'b0, intr}, 32'h1);
    writeReg(3'd1, 32'h00);
    step();
    checkOutput("spur_withdrawn", {31'b0, intr}, 32'h0);
    applyStimulus(8'h00, 1'b1);
    checkReg("spur_vec", 3'd4, 32'h0000_0008);
    checkReg("spur_isr", 3'd3, 32'h00);
    checkReg("spur_pend", 3'd0, 32'h01);

    // Reset while requesting with PEND=0x21
    writeReg(3'd1, 32'hFF);
    applyStimulus(8'h20, 1'b0);
    irq_src = 8'h00;
    checkOutput("rst_pre_intr", {31'b0, intr}, 32'h1);
    checkReg("rst_pre_pend", 3'd0, 32'h21);
    clrn = 1'b1;
    step();
    clrn = 1'b0;
    checkOutput("rst_intr", {31'b0, intr}, 32'h0);
    for (int a = 0; a < 8; a++) begin
      checkReg($sformatf("rst_reg%0d", a), 3'(a), 32'h0);
    end
    writeReg(3'd6, 32'hFFFF_FFFF);
    checkReg("addr6_ignored", 3'd6, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
